// File: rtl/bit_serial_subtractor.sv
// LSB-first bit-serial subtractor: one full-subtractor cell plus a borrow flop
// computes a - b over WIDTH clocks, with borrow-out, signed overflow and busy/done.
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             write,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg_a;
    logic [WIDTH-1:0] sreg_b;
    logic [WIDTH-1:0] sreg_d;
    logic [CW-1:0]    count;
    logic             br;

    logic a0;
    logic b0;
    logic d;
    logic br_next;
    logic last_bit;

    assign a0       = sreg_a[0];
    assign b0       = sreg_b[0];
    assign d        = a0 ^ b0 ^ br;
    assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
    assign last_bit = (count == CW'(WIDTH - 1));

    // diff/bout/ovf are only touched on the final bit edge, so the previous
    // result stays visible while the next operation is in flight.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            sreg_a <= '0;
            sreg_b <= '0;
            sreg_d <= '0;
            count  <= '0;
            br     <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (write) begin
                        sreg_a <= a;
                        sreg_b <= b;
                        br     <= 1'b0;
                        count  <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (write) begin
                        sreg_a <= a;
                        sreg_b <= b;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_a <= {1'b0, sreg_a[WIDTH-1:1]};
                    sreg_b <= {1'b0, sreg_b[WIDTH-1:1]};
                    sreg_d <= {d, sreg_d[WIDTH-1:1]};
                    br     <= br_next;
                    count  <= count + 1'b1;
                    if (last_bit) begin
                        // a0/b0 are the operand MSBs here.
                        diff  <= {d, sreg_d[WIDTH-1:1]};
                        bout  <= br_next;
                        ovf   <= (a0 != b0) & (d != a0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench for bit_serial_subtractor: driver pushes model results,
// a monitor pops and compares on each rising edge of done.
module tb_bit_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr;
    logic         write;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         busy;
    logic         done;

    // Expected {diff, bout, ovf}
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_res;
    int           tests = 0;
    int           fails = 0;
    logic         done_q = 1'b0;

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .write(write), .a(a), .b(b),
        .diff(diff), .bout(bout), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int ux;
        int uy;
        int sd;
        logic [W-1:0] dv;
        logic bo;
        logic ov;
        ux = int'(x);
        uy = int'(y);
        sd = int'($signed(x)) - int'($signed(y));
        dv = W'(ux - uy + (1 << W));
        bo = (ux < uy);
        ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
        return {dv, bo, ov};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: one result per done rising edge.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL result: got 0x%0h with no expected entry", {diff, bout, ovf});
            end else begin
                check("result", 32'({diff, bout, ovf}), 32'(exp_q.pop_front()));
            end
        end
        done_q <= done;
    end

    task automatic drive_load(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        write = 1'b1;
        a = x;
        b = y;
    endtask

    // Drop write, then count edges to done; glitch injects a write pulse mid-SHIFT.
    task automatic start_and_wait(input logic [W-1:0] x, input logic [W-1:0] y, input bit glitch);
        int  got_n;
        bit  busy_ok;
        bit  hold_ok;
        got_n   = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        @(negedge clk);
        write = 1'b0;
        exp_q.push_back(model(x, y));
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got_n = n;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if ({diff, bout, ovf} !== last_res) hold_ok = 1'b0;
            if (glitch && n == 5) begin
                write = 1'b1;
                a = 8'd1;
                b = 8'd1;
            end
            if (glitch && n == 6) write = 1'b0;
        end
        write = 1'b0;
        check("latency", 32'(got_n), 32'(W + 1));
        check("busy_during_op", 32'(busy_ok), 32'd1);
        check("hold_during_op", 32'(hold_ok), 32'd1);
        if (got_n == 0) void'(exp_q.pop_front());
        last_res = model(x, y);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        drive_load(x, y);
        start_and_wait(x, y, 1'b0);
    endtask

    initial begin
        clr      = 1'b1;
        write    = 1'b0;
        a        = '0;
        b        = '0;
        last_res = '0;
        #1;
        check("reset_outputs", 32'({diff, bout, ovf, busy, done}), 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b0;

        run_op(8'd145, 8'd123);
        run_op(8'd123, 8'd145);
        run_op(8'h80, 8'h01);
        run_op(8'h7F, 8'hFF);

        // write held for three cycles while a changes; last value wins
        drive_load(8'd10, 8'd48);
        drive_load(8'd13, 8'd48);
        drive_load(8'd16, 8'd48);
        start_and_wait(8'd16, 8'd48, 1'b0);

        // write pulse mid-SHIFT must be ignored
        drive_load(8'd77, 8'd200);
        start_and_wait(8'd77, 8'd200, 1'b1);

        // clr mid-SHIFT discards the partial result immediately
        drive_load(8'd50, 8'd9);
        @(negedge clk);
        write = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        check("clr_mid_shift", 32'({diff, bout, ovf, busy, done}), 32'd0);
        last_res = '0;
        @(negedge clk);
        clr = 1'b0;
        run_op(8'd9, 8'd50);

        run_op(8'd200, 8'd200);

        // Back-to-back from DONE: done drops on the load edge, result holds
        drive_load(8'd3, 8'd250);
        @(posedge clk);
        #1;
        check("done_drops_on_load", 32'(done), 32'd0);
        check("result_held_on_load", 32'({diff, bout, ovf}), 32'(last_res));
        start_and_wait(8'd3, 8'd250, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            int hold;
            rx   = W'($urandom);
            ry   = W'($urandom);
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) drive_load(rx, ry);
            start_and_wait(rx, ry, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
